// File: rtl/ecc_ladder_seq_if.sv
// Handshake bundle between the ladder scheduler and its requester / point-op datapath.
interface ecc_ladder_seq_if #(
  parameter int KW   = 233,
  parameter int IDXW = 8
);
  logic            start;
  logic [KW-1:0]   k;
  logic            busy;
  logic            pm_valid;
  logic            err;
  logic            op_start;
  logic [1:0]      op_code;
  logic            op_swap;
  logic            op_done;
  logic [IDXW-1:0] bit_idx;

  modport master (
    output start, k, op_done,
    input  busy, pm_valid, err, op_start, op_code, op_swap, bit_idx
  );

  modport slave (
    input  start, k, op_done,
    output busy, pm_valid, err, op_start, op_code, op_swap, bit_idx
  );
endinterface

// File: rtl/ecc_ladder_seq.sv
// Montgomery-ladder command scheduler for GF(2^233) scalar multiplication.
// Define LADDER_CONST_TIME_EN for the fixed-latency ladder (no leading-zero scan).
module ecc_ladder_seq #(
  parameter int KW   = 233,
  parameter int IDXW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ecc_ladder_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_FAIL
  } state_t;

  localparam logic [1:0]      OP_INIT = 2'd0;
  localparam logic [1:0]      OP_MADD = 2'd1;
  localparam logic [1:0]      OP_MDBL = 2'd2;
  localparam logic [1:0]      OP_CONV = 2'd3;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(KW - 1);

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [IDXW-1:0] r_idx;
  logic            r_busy;
  logic            r_pm_valid;
  logic            r_err;
  logic            r_op_start;
  logic [1:0]      r_op_code;
  logic            r_op_swap;

  logic [IDXW-1:0] w_idx_m1;
  logic            w_bit_cur;
  logic            w_bit_m1;
  logic            w_idx_zero;

  assign w_idx_m1   = r_idx - 1'b1;
  assign w_bit_cur  = r_k[r_idx];
  assign w_bit_m1   = r_k[w_idx_m1];
  assign w_idx_zero = (r_idx == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_pm_valid <= 1'b0;
      r_err      <= 1'b0;
      r_op_start <= 1'b0;
      r_op_code  <= OP_INIT;
      r_op_swap  <= 1'b0;
    end else begin
      r_pm_valid <= 1'b0;
      r_err      <= 1'b0;
      r_op_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.k == '0) begin
              r_err   <= 1'b1;
              r_state <= S_FAIL;
            end else begin
              r_k    <= bus.k;
              r_idx  <= IDX_TOP;
              r_busy <= 1'b1;
`ifdef LADDER_CONST_TIME_EN
              // Start from (O,P) so the top bit is processed like every other bit
              r_op_code  <= OP_INIT;
              r_op_swap  <= 1'b1;
              r_op_start <= 1'b1;
              r_state    <= S_ISSUE;
`else
              r_state <= S_SCAN;
`endif
            end
          end
        end
        S_SCAN: begin
          if (w_bit_cur) begin
            r_op_code  <= OP_INIT;
            r_op_swap  <= 1'b0;
            r_op_start <= 1'b1;
            r_state    <= S_ISSUE;
          end else begin
            r_idx <= w_idx_m1;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.op_done) begin
            case (r_op_code)
              OP_INIT: begin
                r_op_start <= 1'b1;
                r_state    <= S_ISSUE;
`ifdef LADDER_CONST_TIME_EN
                r_op_code  <= OP_MADD;
                r_op_swap  <= w_bit_cur;
`else
                if (w_idx_zero) begin
                  r_op_code <= OP_CONV;
                  r_op_swap <= 1'b0;
                end else begin
                  r_idx     <= w_idx_m1;
                  r_op_code <= OP_MADD;
                  r_op_swap <= w_bit_m1;
                end
`endif
              end
              OP_MADD: begin
                r_op_code  <= OP_MDBL;
                r_op_start <= 1'b1;
                r_state    <= S_ISSUE;
              end
              OP_MDBL: r_state <= S_NEXT;
              default: begin
                r_pm_valid <= 1'b1;
                r_state    <= S_DONE;
              end
            endcase
          end
        end
        S_NEXT: begin
          r_op_start <= 1'b1;
          r_state    <= S_ISSUE;
          if (w_idx_zero) begin
            r_op_code <= OP_CONV;
            r_op_swap <= 1'b0;
          end else begin
            r_idx     <= w_idx_m1;
            r_op_code <= OP_MADD;
            r_op_swap <= w_bit_m1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAIL:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.pm_valid = r_pm_valid;
  assign bus.err      = r_err;
  assign bus.op_start = r_op_start;
  assign bus.op_code  = r_op_code;
  assign bus.op_swap  = r_op_swap;
  assign bus.bit_idx  = r_idx;

endmodule

// File: tb/tb_ecc_ladder_seq.sv
// Scoreboard bench for ecc_ladder_seq: expected command trace queued per scalar,
// checked against every OP_START issued, with a fixed-latency datapath responder.
module tb_ecc_ladder_seq;
  localparam int KW   = 233;
  localparam int IDXW = 8;
  localparam int LAT  = 3;
  localparam int TMO  = 8000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dp_done = 1'b0;
  logic spur_done = 1'b0;
  int   dp_cnt = 0;

  ecc_ladder_seq_if #(.KW(KW), .IDXW(IDXW)) ifc ();

  ecc_ladder_seq #(.KW(KW), .IDXW(IDXW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  assign ifc.op_done = dp_done | spur_done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmd = 0, madd_seen = 0, pm_cnt = 0, err_cnt = 0, busy_cnt = 0;
  logic [IDXW+2:0] sb[$];
  logic [IDXW+2:0] exp_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference command trace for one multiplication; returns the command count.
  function automatic int push_model(input logic [KW-1:0] kv);
    int top = 0;
    int cnt = 0;
    for (int i = 0; i < KW; i++) if (kv[i]) top = i;
`ifdef LADDER_CONST_TIME_EN
    sb.push_back({2'd0, 1'b1, IDXW'(KW - 1)});
    top = KW;
`else
    sb.push_back({2'd0, 1'b0, IDXW'(top)});
`endif
    cnt = 1;
    for (int i = top - 1; i >= 0; i--) begin
      sb.push_back({2'd1, kv[i], IDXW'(i)});
      sb.push_back({2'd2, kv[i], IDXW'(i)});
      cnt += 2;
    end
    sb.push_back({2'd3, 1'b0, IDXW'(0)});
    return cnt + 1;
  endfunction

  // Datapath model: OP_DONE pulse LAT cycles after each OP_START.
  always @(negedge clk) begin
    if (!rst_n) begin
      dp_cnt  = 0;
      dp_done = 1'b0;
    end else begin
      dp_done = 1'b0;
      if (dp_cnt != 0) begin
        dp_cnt--;
        if (dp_cnt == 0) dp_done = 1'b1;
      end else if (ifc.op_start) begin
        dp_cnt = LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (ifc.op_start) begin
      n_cmd++;
      if (ifc.op_code == 2'd1) madd_seen++;
      if (sb.size() == 0) chk("cmd_unexpected", ifc.op_start, 1'b0);
      else begin
        exp_e = sb.pop_front();
        chk("cmd", {ifc.op_code, ifc.op_swap, ifc.bit_idx}, exp_e);
      end
    end
    if (ifc.pm_valid) pm_cnt++;
    if (ifc.err)      err_cnt++;
    if (ifc.busy)     busy_cnt++;
  end

  task automatic run_k(input logic [KW-1:0] kv, input bit spur, output int cyc);
    int c0 = n_cmd;
    int p0 = pm_cnt;
    int e0 = err_cnt;
    int ncmd_exp;
    bit done = 1'b0;
    ncmd_exp = push_model(kv);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.k     = kv;
    @(negedge clk);
    #1;
    ifc.start = 1'b0;
    cyc = 1;
    for (int i = 0; i < TMO && !done; i++) begin
      if (spur) begin
        ifc.start = (i >= 3 && i <= 6);
        if (i == 3) ifc.k = '1;
`ifndef LADDER_CONST_TIME_EN
        spur_done = (i == 4 || i == 9);
`endif
      end
      @(negedge clk);
      #1;
      cyc++;
      if (ifc.pm_valid) begin
        done = 1'b1;
        chk("busy_at_pm", ifc.busy, 1'b1);
        @(negedge clk);
        #1;
        chk("busy_after_pm", ifc.busy, 1'b0);
        chk("pm_pulse_width", ifc.pm_valid, 1'b0);
      end
    end
    ifc.start = 1'b0;
    spur_done = 1'b0;
    chk("pm_seen", done, 1'b1);
    chk("ncmd", n_cmd - c0, ncmd_exp);
    chk("sb_left", sb.size(), 0);
    chk("pm_cnt", pm_cnt - p0, 1);
    chk("err_cnt", err_cnt - e0, 0);
    sb.delete();
  endtask

  logic [KW-1:0] kv;
  int cyc_a, cyc_b;
  int c0, p0, e0, b0;
  bit hit;

  initial begin
    ifc.start = 1'b0;
    ifc.k     = '0;
    #1;
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_pm", ifc.pm_valid, 1'b0);
    chk("rst_opstart", ifc.op_start, 1'b0);
    chk("rst_idx", ifc.bit_idx, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    kv = '0; kv[0] = 1'b1;
    run_k(kv, 1'b0, cyc_a);
    kv = '0; kv[KW-1] = 1'b1;
    run_k(kv, 1'b0, cyc_b);
`ifdef LADDER_CONST_TIME_EN
    chk("ct_cycles_equal", cyc_b, cyc_a);
`endif
    kv = KW'(5);
    run_k(kv, 1'b0, cyc_a);

    // K == 0 is rejected with a single ERR pulse and no commands
    c0 = n_cmd; p0 = pm_cnt; e0 = err_cnt; b0 = busy_cnt;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.k     = '0;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("zero_err", err_cnt - e0, 1);
    chk("zero_cmds", n_cmd - c0, 0);
    chk("zero_pm", pm_cnt - p0, 0);
    chk("zero_busy", busy_cnt - b0, 0);

    kv = KW'(5);
    run_k(kv, 1'b1, cyc_b);
    chk("spur_cycles", cyc_b, cyc_a);

    // Reset while waiting on the second MADD
    p0 = pm_cnt; e0 = err_cnt;
    madd_seen = 0;
    void'(push_model(KW'(5)));
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.k     = KW'(5);
    @(negedge clk);
    ifc.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < TMO && !hit; i++) begin
      @(negedge clk);
      #1;
      if (madd_seen >= 2) hit = 1'b1;
    end
    chk("madd2_seen", hit, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", ifc.busy, 1'b0);
    chk("mid_rst_opstart", ifc.op_start, 1'b0);
    chk("mid_rst_opcode", ifc.op_code, 2'd0);
    chk("mid_rst_swap", ifc.op_swap, 1'b0);
    chk("mid_rst_idx", ifc.bit_idx, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rst_no_pm", pm_cnt - p0, 0);
    chk("mid_rst_no_err", err_cnt - e0, 0);

    kv = KW'(3);
    run_k(kv, 1'b0, cyc_a);

    kv = KW'($urandom_range(1, 255));
    run_k(kv, 1'b0, cyc_a);
    for (int n = 0; n < 2; n++) begin
      for (int w = 0; w < KW; w += 32) kv[w +: 32] = $urandom;
      run_k(kv, 1'b0, cyc_a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
